// File: rtl/queue_4in1.sv
// queue_4in1: four-wide dispatch, single-issue queue with tag wakeup and branch kill.
// Define QUEUE_4IN1_WAKEUP_BYPASS_EN to wake incoming entries against i_wdest4x in their dispatch cycle.
module queue_4in1 #(
  parameter int  WIDTH_REG = 3,
  parameter int  WIDTH_TAG = 3,
  parameter int  WIDTH_BRM = 3,
  parameter int  DEPTH     = 8,
  localparam int WIDTH     = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [WIDTH-1:0]       i_inst1,
  input  logic [WIDTH-1:0]       i_inst2,
  input  logic [WIDTH-1:0]       i_inst3,
  input  logic [WIDTH-1:0]       i_inst4,
  input  logic [4*WIDTH_REG-1:0] i_wdest4x,
  input  logic [WIDTH_BRM-1:0]   i_BrKill,
  input  logic                   i_en,
  output logic [WIDTH-4:0]       o_inst1,
  output logic                   o_ready,
  output logic                   o_full
);

  localparam int P1    = 0;
  localparam int P2    = 1;
  localparam int VAL   = 2;
  localparam int PR1   = 3;
  localparam int PR2   = PR1 + WIDTH_REG;
  localparam int BRM   = 3 + 3*WIDTH_REG + WIDTH_TAG;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_d [DEPTH];
  logic [WIDTH-1:0] inst_in [4];
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] claimed;
  logic             sel_found;
  logic [CNT_W-1:0] free_cnt;

  assign inst_in[0] = i_inst1;
  assign inst_in[1] = i_inst2;
  assign inst_in[2] = i_inst3;
  assign inst_in[3] = i_inst4;

  function automatic logic tag_hit(input logic [WIDTH_REG-1:0]   tag,
                                   input logic [4*WIDTH_REG-1:0] wdest);
    tag_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (wdest[k*WIDTH_REG +: WIDTH_REG] == tag) tag_hit = 1'b1;
    end
  endfunction

  // Select: lowest-index slot whose operands are both present.
  always_comb begin
    sel_oh    = '0;
    sel_found = 1'b0;
    o_inst1   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && slot_q[i][VAL] && slot_q[i][P1] && slot_q[i][P2]) begin
        sel_oh[i] = 1'b1;
        sel_found = 1'b1;
        o_inst1   = slot_q[i][WIDTH-1:3];
      end
    end
  end

  assign o_ready = sel_found;

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!slot_q[i][VAL]) free_cnt = free_cnt + 1'b1;
    end
  end

  assign o_full = (free_cnt < CNT_W'(4));

  // NOTE: slot_d starts as a copy of slot_q so every path assigns it and no latch is inferred.
  always_comb begin : next_state_p
    logic [WIDTH-1:0] entry;
    logic             placed;
    slot_d  = slot_q;
    claimed = '0;
    entry   = '0;
    placed  = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (slot_q[i][VAL]) begin
        if (tag_hit(slot_q[i][PR1 +: WIDTH_REG], i_wdest4x)) slot_d[i][P1] = 1'b1;
        if (tag_hit(slot_q[i][PR2 +: WIDTH_REG], i_wdest4x)) slot_d[i][P2] = 1'b1;
        if (sel_oh[i] || |(slot_q[i][BRM +: WIDTH_BRM] & i_BrKill)) slot_d[i][VAL] = 1'b0;
      end
    end

    // Free slots come from the registered val bits, so a slot issuing this cycle stays unavailable.
    for (int n = 0; n < 4; n++) begin
      entry = inst_in[n];
`ifdef QUEUE_4IN1_WAKEUP_BYPASS_EN
      if (tag_hit(entry[PR1 +: WIDTH_REG], i_wdest4x)) entry[P1] = 1'b1;
      if (tag_hit(entry[PR2 +: WIDTH_REG], i_wdest4x)) entry[P2] = 1'b1;
`endif
      placed = 1'b0;
      if (i_en && entry[VAL] && !(|(entry[BRM +: WIDTH_BRM] & i_BrKill))) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!placed && !slot_q[i][VAL] && !claimed[i]) begin
            slot_d[i]  = entry;
            claimed[i] = 1'b1;
            placed     = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the slot array is reset because its val bits define occupancy; unreset slots would look live.
  // NOTE: non-blocking assignments so every slot updates from the same pre-edge snapshot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: tb/tb_queue_4in1.sv
// tb_queue_4in1: directed vector table, hand-written corner sequences and a randomized run
// against a slot-list reference model for queue_4in1.
module tb_queue_4in1;
  localparam int W = 25;
  localparam logic [11:0] IDLE = 12'hFFF;
  localparam logic [W-1:0] Z = '0;
`ifdef QUEUE_4IN1_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          i_clk, i_rst_n, i_en;
  logic [W-1:0]  i_inst1, i_inst2, i_inst3, i_inst4;
  logic [11:0]   i_wdest4x;
  logic [2:0]    i_BrKill;
  logic [21:0]   o_inst1;
  logic          o_ready, o_full;

  int n_vec = 0;
  int n_err = 0;

  queue_4in1 dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_inst1(i_inst1), .i_inst2(i_inst2), .i_inst3(i_inst3), .i_inst4(i_inst4),
    .i_wdest4x(i_wdest4x), .i_BrKill(i_BrKill), .i_en(i_en),
    .o_inst1(o_inst1), .o_ready(o_ready), .o_full(o_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] mk(input logic [6:0] uop, input logic [2:0] brm, tag, prd, pr2, pr1,
                                      input logic v, p2, p1);
    return {uop, brm, tag, prd, pr2, pr1, v, p2, p1};
  endfunction

  function automatic logic [21:0] up(input logic [W-1:0] e);
    return e[24:3];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic r, input logic [21:0] inst, input logic f);
    check({name, ".ready"}, 32'(o_ready), 32'(r));
    check({name, ".inst"},  32'(o_inst1), 32'(inst));
    check({name, ".full"},  32'(o_full),  32'(f));
  endtask

  task automatic drive(input logic en, input logic [W-1:0] a, b, c, d, input logic [11:0] wd,
                       input logic [2:0] kill);
    i_en = en; i_inst1 = a; i_inst2 = b; i_inst3 = c; i_inst4 = d;
    i_wdest4x = wd; i_BrKill = kill;
  endtask

  typedef struct {
    logic         en;
    logic [W-1:0] in1, in2, in3, in4;
    logic [11:0]  wd;
    logic [2:0]   kill;
    logic         exp_rdy;
    logic [21:0]  exp_inst;
    logic         exp_full;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic en, input logic [W-1:0] a, b, c, d, input logic [11:0] wd,
                     input logic [2:0] kill, input logic r, input logic [21:0] inst, input logic f);
    vec_t v;
    v.en = en; v.in1 = a; v.in2 = b; v.in3 = c; v.in4 = d; v.wd = wd; v.kill = kill;
    v.exp_rdy = r; v.exp_inst = inst; v.exp_full = f;
    tbl.push_back(v);
  endtask

  // Reference model: a list of occupied issue slots, decoded into fields.
  typedef struct {
    bit v, p1, p2;
    bit [2:0] pr1, pr2, brm;
    bit [21:0] body;
  } mslot_t;
  mslot_t m [8];

  function automatic mslot_t dec(input logic [W-1:0] e);
    mslot_t s;
    s.p1 = e[0]; s.p2 = e[1]; s.v = e[2];
    s.pr1 = e[5:3]; s.pr2 = e[8:6]; s.brm = e[17:15]; s.body = e[24:3];
    return s;
  endfunction

  function automatic bit hit(input logic [2:0] t, input logic [11:0] wd);
    return (t == wd[2:0]) || (t == wd[5:3]) || (t == wd[8:6]) || (t == wd[11:9]);
  endfunction

  function automatic logic [W-1:0] rand_entry();
    logic [2:0] brm;
    brm = ($urandom_range(3, 0) == 0) ? 3'(1 << $urandom_range(2, 0)) : 3'd0;
    return mk(7'($urandom), brm, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
              ($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom));
  endfunction

  task automatic model_advance(input logic en, input logic [W-1:0] ins [4], input logic [11:0] wd,
                               input logic [2:0] kill, input int sel);
    int free_q[$];
    mslot_t e;
    for (int i = 0; i < 8; i++) if (!m[i].v) free_q.push_back(i);
    for (int i = 0; i < 8; i++) begin
      if (m[i].v) begin
        m[i].p1 = m[i].p1 | hit(m[i].pr1, wd);
        m[i].p2 = m[i].p2 | hit(m[i].pr2, wd);
        if ((m[i].brm & kill) != 0 || i == sel) m[i].v = 1'b0;
      end
    end
    if (en) begin
      for (int n = 0; n < 4; n++) begin
        e = dec(ins[n]);
        if (BYP) begin
          e.p1 = e.p1 | hit(e.pr1, wd);
          e.p2 = e.p2 | hit(e.pr2, wd);
        end
        if (e.v && (e.brm & kill) == 0 && free_q.size() > 0) m[free_q.pop_front()] = e;
      end
    end
  endtask

  logic [W-1:0] a [4], c [4], d [4], e [4], f [4];
  logic [W-1:0] b0, byp_e;
  logic [W-1:0] r_ins [4];
  logic         r_en, exp_rdy;
  logic [11:0]  r_wd;
  logic [2:0]   r_kill, pr;
  logic [21:0]  exp_inst;
  int           sel, free_n;

  initial begin
    i_rst_n = 1'b0;
    drive(1'b0, Z, Z, Z, Z, IDLE, 3'd0);

    // Reset then idle.
    repeat (2) begin
      @(negedge i_clk); #1;
      check_outs("reset", 1'b0, 22'd0, 1'b0);
    end
    i_rst_n = 1'b1;
    repeat (2) begin
      @(negedge i_clk); #1;
      check_outs("idle", 1'b0, 22'd0, 1'b0);
    end

    for (int k = 0; k < 4; k++) begin
      a[k] = mk(7'(16 + k), 3'd0, 3'(k), 3'(k + 1), 3'(k + 2), 3'(k + 3), 1'b1, 1'b1, 1'b1);
      c[k] = mk(7'(32 + k), (k % 2 == 0) ? 3'b001 : 3'b010, 3'(k), 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
      d[k] = mk(7'(48 + k), 3'd0, 3'(k), 3'(k), 3'(k), 3'(k), 1'b1, 1'b0, 1'b0);
      pr   = (k == 3) ? 3'd1 : 3'(4 + k);
      e[k] = mk(7'(52 + k), 3'd0, 3'(4 + k), pr, pr, pr, 1'b1, 1'b0, 1'b0);
      f[k] = mk(7'(64 + k), 3'd0, 3'(k), 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    end
    b0 = mk(7'h55, 3'd0, 3'd5, 3'd6, 3'd1, 3'b110, 1'b1, 1'b1, 1'b0);

    // Four ready entries issue in slot order, one per cycle.
    add(1, a[0], a[1], a[2], a[3], IDLE, 0, 0, 22'd0, 0);
    add(0, Z, Z, Z, Z, IDLE, 0, 1, up(a[0]), 0);
    add(0, Z, Z, Z, Z, IDLE, 0, 1, up(a[1]), 0);
    add(0, Z, Z, Z, Z, IDLE, 0, 1, up(a[2]), 0);
    add(0, Z, Z, Z, Z, IDLE, 0, 1, up(a[3]), 0);
    // Wakeup of pr1=110 one cycle after dispatch.
    add(1, b0, Z, Z, Z, IDLE, 0, 0, 22'd0, 0);
    add(0, Z, Z, Z, Z, 12'hC00, 0, 0, 22'd0, 0);
    add(0, Z, Z, Z, Z, IDLE, 0, 1, up(b0), 0);
    // Branch kill of the BrM=010 entries.
    add(1, c[0], c[1], c[2], c[3], IDLE, 0, 0, 22'd0, 0);
    add(0, Z, Z, Z, Z, IDLE, 3'b010, 1, up(c[0]), 0);
    add(0, Z, Z, Z, Z, IDLE, 0, 1, up(c[2]), 0);
    // Fill with eight waiting entries, then issue one.
    add(1, d[0], d[1], d[2], d[3], IDLE, 0, 0, 22'd0, 0);
    add(1, e[0], e[1], e[2], e[3], IDLE, 0, 0, 22'd0, 0);
    add(0, Z, Z, Z, Z, 12'hFF8, 0, 0, 22'd0, 1);
    add(0, Z, Z, Z, Z, IDLE, 0, 1, up(d[0]), 1);
    add(0, Z, Z, Z, Z, IDLE, 0, 0, 22'd0, 1);
    // Overflow: only the first entry finds the single free slot.
    add(1, f[0], f[1], f[2], f[3], IDLE, 0, 0, 22'd0, 1);
    add(0, Z, Z, Z, Z, IDLE, 0, 1, up(f[0]), 1);
    add(0, Z, Z, Z, Z, IDLE, 0, 0, 22'd0, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge i_clk);
      drive(tbl[k].en, tbl[k].in1, tbl[k].in2, tbl[k].in3, tbl[k].in4, tbl[k].wd, tbl[k].kill);
      #1;
      check_outs($sformatf("tbl%0d", k), tbl[k].exp_rdy, tbl[k].exp_inst, tbl[k].exp_full);
    end

    // Reset mid-operation discards all seven waiting entries immediately.
    @(negedge i_clk);
    drive(1'b0, Z, Z, Z, Z, IDLE, 3'd0);
    i_rst_n = 1'b0;
    #1;
    check_outs("midreset", 1'b0, 22'd0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_wdest4x = {3'd3, 3'd2, 3'd1, 3'd0};
    @(negedge i_clk);
    i_wdest4x = {3'd1, 3'd6, 3'd5, 3'd4};
    @(negedge i_clk);
    i_wdest4x = IDLE;
    #1;
    check_outs("postreset", 1'b0, 22'd0, 1'b0);

    // Same-cycle tag at dispatch: only caught with the bypass build.
    byp_e = mk(7'h7A, 3'd0, 3'd1, 3'd2, 3'b101, 3'd2, 1'b1, 1'b0, 1'b1);
    @(negedge i_clk);
    drive(1'b1, byp_e, Z, Z, Z, {3'b111, 3'b101, 3'b111, 3'b111}, 3'd0);
    #1;
    check_outs("byp_ins", 1'b0, 22'd0, 1'b0);
    @(negedge i_clk);
    drive(1'b0, Z, Z, Z, Z, IDLE, 3'd0);
    #1;
    check_outs("byp_next", BYP, BYP ? up(byp_e) : 22'd0, 1'b0);
    @(negedge i_clk); #1;
    check_outs("byp_after", 1'b0, 22'd0, 1'b0);

    // Randomized run against the reference model.
    @(negedge i_clk);
    i_rst_n = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = '{default: '0};
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge i_clk);
      r_en   = 1'($urandom);
      for (int n = 0; n < 4; n++) r_ins[n] = rand_entry();
      r_wd   = 12'($urandom);
      r_kill = ($urandom_range(7, 0) == 0) ? 3'($urandom) : 3'd0;
      drive(r_en, r_ins[0], r_ins[1], r_ins[2], r_ins[3], r_wd, r_kill);
      #1;
      exp_rdy = 1'b0; exp_inst = '0; free_n = 0; sel = -1;
      for (int i = 0; i < 8; i++) begin
        if (!m[i].v) free_n++;
        if (!exp_rdy && m[i].v && m[i].p1 && m[i].p2) begin
          exp_rdy = 1'b1; exp_inst = m[i].body; sel = i;
        end
      end
      check_outs($sformatf("rnd%0d", cyc), exp_rdy, exp_inst, free_n < 4);
      model_advance(r_en, r_ins, r_wd, r_kill, sel);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/queue_4in1.md
# queue_4in1

Four-wide-in, one-wide-out issue queue for the out-of-order back end, between rename/dispatch and the execution-unit issue port. Each cycle it accepts up to four renamed micro-ops into free issue slots. It wakes up source operands from four writeback destination tags and squashes entries on branch kill. It presents at most one ready micro-op per cycle to the execution unit.

## Interface
Parameters:
- WIDTH_REG, 3: physical register tag width.
- WIDTH_TAG, 3: ROB tag width.
- WIDTH_BRM, 3: branch mask width.
- DEPTH, 8: number of issue slots; must be ≥4.
- Derived constant WIDTH = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3.
- Instruction packing, MSB to LSB: UOP[6:0], BrM, Tag, prd, pr2, pr1, val, p2, p1.

Ports:
- i_clk, in, 1: clock. Single clock domain.
- i_rst_n, in, 1: asynchronous reset, active-low.
- i_inst1..i_inst4, in, WIDTH each: dispatched micro-ops. An entry is present only when its val bit is 1.
- i_wdest4x, in, 4*WIDTH_REG: four writeback destination tags, concatenated with slot 0 in the LSBs.
- i_BrKill, in, WIDTH_BRM: mask of killed branches.
- i_en, in, 1: dispatch write enable.
- o_inst1, out, WIDTH-3: issued micro-op {UOP, BrM, Tag, prd, pr2, pr1}, with no status bits.
- o_ready, out, 1: o_inst1 is valid and is being issued this cycle.
- o_full, out, 1: fewer than 4 free slots.

## Operation
- **Slot state:** each slot holds the full WIDTH-bit entry. A slot is free when its val bit is 0.
- **Insert:** when i_en=1, each i_instN with val=1 is written into a free slot.
  - Processed in order inst1, inst2, inst3, inst4.
  - Each takes the lowest-index free slot not already claimed.
  - Entries with val=0 are skipped.
  - Free status is taken from the registered state. A slot issued this cycle is not reused until the next cycle.
- **Overflow:** dispatch must not assert i_en while o_full=1. If it does, entries that find no free slot are dropped silently.
- **Wakeup:** for every valid slot, if pr1 equals any of the four i_wdest4x tags, p1 is set at the clock edge. The same rule applies to pr2 and p2. Set bits are never cleared except by slot deallocation.
- **Branch kill:** any slot with (BrM & i_BrKill) != 0 has val cleared at the clock edge. Kill takes priority over wakeup and issue. Incoming entries matching i_BrKill are not inserted.
- **Select:** combinationally pick the lowest-index slot with val & p1 & p2 = 1.
  - o_ready = 1 when such a slot exists. o_inst1 carries its upper WIDTH-3 bits.
  - o_inst1 = 0 when o_ready = 0.
  - The consumer always accepts the issued micro-op. The selected slot's val is cleared at the next edge.
- **o_full** is derived from the registered val bits: count of free slots < 4.

## Timing
- **Reset:** while i_rst_n=0, all slots clear immediately. Outputs: o_ready=0, o_inst1=0, o_full=0. Reset mid-operation discards all entries.
- **Insert to issue:** 1 cycle minimum. An entry written at edge N can drive o_ready in the cycle after edge N.
- **Wakeup:** a tag on i_wdest4x during cycle N makes the waiting slot selectable after edge N.
- **Throughput:** one issue per cycle, up to 4 inserts per cycle.
- **Simultaneous kill and select on one slot:** o_ready is still asserted that cycle, because select is combinational from registered state. Killing is the branch unit's responsibility downstream.

## Configuration
- QUEUE_4IN1_WAKEUP_BYPASS_EN
  - Defined: incoming entries are also compared against i_wdest4x in the insert cycle, and p1/p2 are stored already set on a match.
  - Undefined: incoming p1/p2 are stored exactly as presented. A tag broadcast in the same cycle as dispatch is missed for that entry.

## Test plan
All scenarios use WIDTH_REG=3, WIDTH_TAG=3, WIDTH_BRM=3, DEPTH=8, so WIDTH=25.
- **Reset then idle:** pulse i_rst_n low, hold i_en=0 → o_ready=0, o_inst1=0, o_full=0 on every cycle.
- **Insert 4 fully-ready entries** (val=p1=p2=1, BrM=000), with i_BrKill=000 → o_ready=1 for exactly 4 consecutive cycles starting the cycle after insertion, issuing slots 0..3 in order. Each o_inst1 equals the entry's upper 22 bits.
- **Insert an entry with pr1=3'b110, p1=0, p2=1**; one cycle later drive i_wdest4x={110,000,000,000} → o_ready rises the cycle after the broadcast with that entry.
- **Branch kill:** insert 4 ready entries with BrM=010 and 001 alternating; next cycle drive i_BrKill=010 → only the two BrM=001 entries ever issue.
- **Fill:** insert 4+4 not-ready entries → o_full=1 after the second edge. Issue one entry → o_full remains 1 because only 1 slot is free.
- **Bypass, same-cycle tag:** dispatch an entry with pr2=101, p2=0 while i_wdest4x contains 101.
  - With QUEUE_4IN1_WAKEUP_BYPASS_EN defined → it issues the next cycle.
  - Without the macro → it never issues.
